// File: rtl/gr_cordic_pipe_pkg.sv
// Shared codes, modes and scale-compensation constants for the Givens-rotation CORDIC pipeline.
// Pure definitions: no logic, no latency, no flow control.
// Imported by the stage and top-level modules.
package gr_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_MINUS = 2'd0;
    localparam dir_t DIR_PLUS  = 2'd1;
    localparam dir_t DIR_SKIP  = 2'd2;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // K ~= 0.6074 as v/2 + v/8 - v/64 - v/512
    localparam int SC_SH0 = 1;
    localparam int SC_SH1 = 3;
    localparam int SC_SH2 = 6;
    localparam int SC_SH3 = 9;

endpackage

// File: rtl/gr_cordic_pipe_if.sv
// Beat interface of the CORDIC pipeline: operands/codes in, results/applied codes out.
// No logic; latency is owned by the engine.
// valid/ready on both sides; the master drives in_* and out_ready.
interface gr_cordic_pipe_if #(
    parameter int R_LEN  = 12,
    parameter int N_ITER = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic                     in_nop;
    logic                     in_neg;
    logic signed [R_LEN-1:0]  in_x;
    logic signed [R_LEN-1:0]  in_y;
    logic [2*N_ITER-1:0]      in_dir;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_neg;
    logic signed [R_LEN-1:0]  out_x;
    logic signed [R_LEN-1:0]  out_y;
    logic [2*N_ITER-1:0]      out_dir;

    modport master (
        output in_valid, in_mode, in_nop, in_neg, in_x, in_y, in_dir, out_ready,
        input  in_ready, out_valid, out_neg, out_x, out_y, out_dir
    );

    modport slave (
        input  in_valid, in_mode, in_nop, in_neg, in_x, in_y, in_dir, out_ready,
        output in_ready, out_valid, out_neg, out_x, out_y, out_dir
    );
endinterface

// File: rtl/gr_cordic_pipe_stage.sv
// Combinational chain of MR_PER_STG micro-rotations with shifts BASE..BASE+MR_PER_STG-1.
// Latency: zero (purely combinational).
// No flow control; the enclosing pipeline registers hold it under stall.
module gr_stage
    import gr_pkg::*;
#(
    parameter int R_LEN      = 12,
    parameter int MR_PER_STG = 4,
    parameter int BASE       = 0
) (
    input  logic                      i_mode,
    input  logic                      i_nop,
    input  logic signed [R_LEN-1:0]   i_x,
    input  logic signed [R_LEN-1:0]   i_y,
    input  logic [2*MR_PER_STG-1:0]   i_dir,
    output logic signed [R_LEN-1:0]   o_x,
    output logic signed [R_LEN-1:0]   o_y,
    output logic [2*MR_PER_STG-1:0]   o_dir
);

    logic signed [R_LEN-1:0] xc, yc, xn, yn;
    dir_t                    d;

    always_comb begin
        xc    = i_x;
        yc    = i_y;
        xn    = i_x;
        yn    = i_y;
        d     = DIR_SKIP;
        o_dir = '0;
        for (int k = 0; k < MR_PER_STG; k++) begin
            // Vectoring drives y toward zero using the sign of y entering this micro-rotation
            if (i_nop)
                d = DIR_SKIP;
            else if (i_mode == MODE_VEC)
                d = yc[R_LEN-1] ? DIR_PLUS : DIR_MINUS;
            else
                d = i_dir[2*k +: 2];
            xn = xc;
            yn = yc;
            case (d)
                DIR_MINUS: begin
                    xn = xc + (yc >>> (BASE + k));
                    yn = yc - (xc >>> (BASE + k));
                end
                DIR_PLUS: begin
                    xn = xc - (yc >>> (BASE + k));
                    yn = yc + (xc >>> (BASE + k));
                end
                default: ;
            endcase
            o_dir[2*k +: 2] = d;
            xc = xn;
            yc = yn;
        end
        o_x = xc;
        o_y = yc;
    end

endmodule

// File: rtl/gr_cordic_pipe.sv
// Pipelined Givens-rotation CORDIC (rotation/vectoring); GR_SCALE_COMP_EN adds a gain-compensation stage.
// Latency N_ITER/MR_PER_STG cycles, one more with GR_SCALE_COMP_EN.
// Global stall: every register holds while out_valid && !out_ready; in_ready mirrors the advance.
module gr_cordic_pipe
    import gr_pkg::*;
#(
    parameter int R_LEN      = 12,
    parameter int R_FRAC     = 2,
    parameter int N_ITER     = 12,
    parameter int MR_PER_STG = 4
) (
    input  logic            clk,
    input  logic            rst,
    gr_cordic_pipe_if.slave io
);

    localparam int STAGES = N_ITER / MR_PER_STG;
    localparam int DW     = 2 * N_ITER;
    localparam int SW     = 2 * MR_PER_STG;

    if ((N_ITER % MR_PER_STG) != 0) begin : g_cfg_iter
        $error("gr_cordic_pipe: N_ITER must be a multiple of MR_PER_STG");
    end
    if ((R_FRAC < 0) || (R_FRAC >= R_LEN)) begin : g_cfg_frac
        $error("gr_cordic_pipe: R_FRAC must lie within the datapath width");
    end

    logic                    adv;
    logic                    out_vld;
    logic                    ent_neg;
    logic signed [R_LEN-1:0] ent_x, ent_y;

    logic [STAGES-1:0]       vld_q, vld_d;
    logic                    mode_q [STAGES];
    logic                    mode_d [STAGES];
    logic                    nop_q  [STAGES];
    logic                    nop_d  [STAGES];
    logic                    neg_q  [STAGES];
    logic                    neg_d  [STAGES];
    logic signed [R_LEN-1:0] x_q    [STAGES];
    logic signed [R_LEN-1:0] x_d    [STAGES];
    logic signed [R_LEN-1:0] y_q    [STAGES];
    logic signed [R_LEN-1:0] y_d    [STAGES];
    logic [DW-1:0]           dir_q  [STAGES];
    logic [DW-1:0]           dir_d  [STAGES];

    logic signed [R_LEN-1:0] src_x   [STAGES];
    logic signed [R_LEN-1:0] src_y   [STAGES];
    logic [DW-1:0]           src_dir [STAGES];
    logic signed [R_LEN-1:0] stg_x   [STAGES];
    logic signed [R_LEN-1:0] stg_y   [STAGES];
    logic [SW-1:0]           stg_dir [STAGES];

    // Pre-negation; a nop beat never negates so it passes through untouched
    always_comb begin
        ent_neg = 1'b0;
        if (!io.in_nop)
            ent_neg = (io.in_mode == MODE_VEC) ? io.in_x[R_LEN-1] : io.in_neg;
        ent_x = ent_neg ? -io.in_x : io.in_x;
        ent_y = ent_neg ? -io.in_y : io.in_y;
    end

    always_comb begin
        vld_d[0]   = io.in_valid;
        mode_d[0]  = io.in_mode;
        nop_d[0]   = io.in_nop;
        neg_d[0]   = ent_neg;
        src_x[0]   = ent_x;
        src_y[0]   = ent_y;
        src_dir[0] = io.in_dir;
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s]   = vld_q[s-1];
            mode_d[s]  = mode_q[s-1];
            nop_d[s]   = nop_q[s-1];
            neg_d[s]   = neg_q[s-1];
            src_x[s]   = x_q[s-1];
            src_y[s]   = y_q[s-1];
            src_dir[s] = dir_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        gr_stage #(
            .R_LEN      (R_LEN),
            .MR_PER_STG (MR_PER_STG),
            .BASE       (s * MR_PER_STG)
        ) u_stage (
            .i_mode (mode_d[s]),
            .i_nop  (nop_d[s]),
            .i_x    (src_x[s]),
            .i_y    (src_y[s]),
            .i_dir  (src_dir[s][SW*s +: SW]),
            .o_x    (stg_x[s]),
            .o_y    (stg_y[s]),
            .o_dir  (stg_dir[s])
        );
    end

    // Each stage replaces its own slice of the code vector with the codes it applied
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            x_d[s]                = stg_x[s];
            y_d[s]                = stg_y[s];
            dir_d[s]              = src_dir[s];
            dir_d[s][SW*s +: SW]  = stg_dir[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                mode_q[s] <= 1'b0;
                nop_q[s]  <= 1'b0;
                neg_q[s]  <= 1'b0;
                x_q[s]    <= '0;
                y_q[s]    <= '0;
                dir_q[s]  <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            for (int s = 0; s < STAGES; s++) begin
                mode_q[s] <= mode_d[s];
                nop_q[s]  <= nop_d[s];
                neg_q[s]  <= neg_d[s];
                x_q[s]    <= x_d[s];
                y_q[s]    <= y_d[s];
                dir_q[s]  <= dir_d[s];
            end
        end
    end

`ifdef GR_SCALE_COMP_EN
    logic                    sc_vld_q, sc_vld_d;
    logic                    sc_neg_q, sc_neg_d;
    logic signed [R_LEN-1:0] sc_x_q, sc_x_d;
    logic signed [R_LEN-1:0] sc_y_q, sc_y_d;
    logic [DW-1:0]           sc_dir_q, sc_dir_d;

    function automatic logic signed [R_LEN-1:0] k_scale(input logic signed [R_LEN-1:0] v);
        return (v >>> SC_SH0) + (v >>> SC_SH1) - (v >>> SC_SH2) - (v >>> SC_SH3);
    endfunction

    always_comb begin
        sc_vld_d = vld_q[STAGES-1];
        sc_neg_d = neg_q[STAGES-1];
        sc_dir_d = dir_q[STAGES-1];
        sc_x_d   = x_q[STAGES-1];
        sc_y_d   = y_q[STAGES-1];
        if (!nop_q[STAGES-1]) begin
            sc_x_d = k_scale(x_q[STAGES-1]);
            sc_y_d = k_scale(y_q[STAGES-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_vld_q <= 1'b0;
            sc_neg_q <= 1'b0;
            sc_dir_q <= '0;
            sc_x_q   <= '0;
            sc_y_q   <= '0;
        end else if (adv) begin
            sc_vld_q <= sc_vld_d;
            sc_neg_q <= sc_neg_d;
            sc_dir_q <= sc_dir_d;
            sc_x_q   <= sc_x_d;
            sc_y_q   <= sc_y_d;
        end
    end

    assign out_vld    = sc_vld_q;
    assign io.out_neg = sc_neg_q;
    assign io.out_dir = sc_dir_q;
    assign io.out_x   = sc_x_q;
    assign io.out_y   = sc_y_q;
`else
    assign out_vld    = vld_q[STAGES-1];
    assign io.out_neg = neg_q[STAGES-1];
    assign io.out_dir = dir_q[STAGES-1];
    assign io.out_x   = x_q[STAGES-1];
    assign io.out_y   = y_q[STAGES-1];
`endif

    assign adv          = !out_vld || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = out_vld;

endmodule
